// File: rtl/i2c_xfer_arbiter_pkg.sv
// Shared definitions for i2c_xfer_arbiter: i2c_master register bit indices
// and the transaction FSM state encodings.
package i2c_xfer_arbiter_pkg;

    // I2CCR bit positions
    localparam int unsigned BIT_I2CCR_MEN  = 7;
    localparam int unsigned BIT_I2CCR_MIEN = 6;
    localparam int unsigned BIT_I2CCR_MSTA = 5;
    localparam int unsigned BIT_I2CCR_MTX  = 4;
    localparam int unsigned BIT_I2CCR_TXAK = 3;
    localparam int unsigned BIT_I2CCR_RSTA = 2;

    // I2CSR bit positions
    localparam int unsigned BIT_I2CSR_MCF   = 7;
    localparam int unsigned BIT_I2CSR_MAAS  = 6;
    localparam int unsigned BIT_I2CSR_MBB   = 5;
    localparam int unsigned BIT_I2CSR_MAL   = 4;
    localparam int unsigned BIT_I2CSR_BCSTM = 3;
    localparam int unsigned BIT_I2CSR_SRW   = 2;
    localparam int unsigned BIT_I2CSR_MIF   = 1;
    localparam int unsigned BIT_I2CSR_RXAK  = 0;

    // Transaction FSM encodings
    localparam logic [3:0] ST_IDLE      = 4'd0;
    localparam logic [3:0] ST_ARB       = 4'd1;
    localparam logic [3:0] ST_START     = 4'd2;
    localparam logic [3:0] ST_ADDR_WAIT = 4'd3;
    localparam logic [3:0] ST_ADDR_CHK  = 4'd4;
    localparam logic [3:0] ST_DATA      = 4'd5;
    localparam logic [3:0] ST_DATA_WAIT = 4'd6;
    localparam logic [3:0] ST_STOP      = 4'd7;
    localparam logic [3:0] ST_FIN       = 4'd8;

    // Single-bit mask for an 8-bit register
    function automatic logic [7:0] reg_bit(input int unsigned b);
        return 8'(1) << b;
    endfunction

endpackage

// File: rtl/i2c_xfer_arbiter_rr_arbiter.sv
// Round-robin picker: first active request after last_grant, wrapping.
module rr_arbiter
    import i2c_xfer_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] last_grant,
    output logic [NUM_REQ-1:0]         gnt,
    output logic [$clog2(NUM_REQ)-1:0] gnt_idx,
    output logic                       gnt_valid
);

    localparam int unsigned IW = $clog2(NUM_REQ);

    // Scan offsets 1..NUM_REQ from last_grant; the first hit wins
    always_comb begin
        gnt       = '0;
        gnt_idx   = '0;
        gnt_valid = 1'b0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            logic [IW-1:0] cand;
            cand = IW'((32'(last_grant) + k) % NUM_REQ);
            if (!gnt_valid && req[cand]) begin
                gnt_valid = 1'b1;
                gnt_idx   = cand;
                gnt[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/i2c_xfer_arbiter.sv
// Shares one i2c_master among NUM_REQ single-byte requesters.
// Optional build macro I2C_ARB_TIMEOUT_EN adds a per-phase watchdog.
module i2c_xfer_arbiter
    import i2c_xfer_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ        = 4,
    parameter logic [7:0]  FDR_VAL        = 8'h2B,
    parameter int unsigned TIMEOUT_CYCLES = 65535
) (
    input  logic                 I_CLK,
    input  logic                 I_RSTN,
    input  logic [NUM_REQ-1:0]   I_REQ,
    input  logic [7*NUM_REQ-1:0] I_DEV_ADDR,
    input  logic [NUM_REQ-1:0]   I_RW,
    input  logic [8*NUM_REQ-1:0] I_WDATA,
    output logic [NUM_REQ-1:0]   O_GNT,
    output logic [NUM_REQ-1:0]   O_DONE,
    output logic                 O_ERR,
    output logic [7:0]           O_RDATA,
    output logic [7:0]           O_I2CCR,
    output logic [7:0]           O_I2CDR,
    output logic [7:0]           O_I2CFDR,
    output logic                 O_TXRX_DONE,
    input  logic [7:0]           I_I2CSR,
    input  logic [7:0]           I_I2CDR
);

    localparam int unsigned IW = $clog2(NUM_REQ);
    localparam logic [7:0] CR_RUN_TX = reg_bit(BIT_I2CCR_MEN) | reg_bit(BIT_I2CCR_MSTA) | reg_bit(BIT_I2CCR_MTX);
    localparam logic [7:0] CR_RUN_RX = reg_bit(BIT_I2CCR_MEN) | reg_bit(BIT_I2CCR_MSTA) | reg_bit(BIT_I2CCR_TXAK);
    localparam logic [7:0] CR_EN     = reg_bit(BIT_I2CCR_MEN);

    logic [3:0]         state;
    logic [IW-1:0]      last_grant, cur_idx;
    logic [6:0]         addr_q;
    logic               rw_q;
    logic [7:0]         wdata_q, rd_byte;
    logic               err_q, rd_valid, mcf_q;
    logic [1:0]         hold_cnt;
    logic [NUM_REQ-1:0] arb_gnt;
    logic [IW-1:0]      arb_idx;
    logic               arb_valid;
    logic [6:0]         sel_addr;
    logic               sel_rw;
    logic [7:0]         sel_wdata;
    logic               sr_mcf, sr_mbb, sr_mal, sr_rxak;
    logic               mcf_evt, abort, to_hit, unused_sr;

    assign sr_mcf    = I_I2CSR[BIT_I2CSR_MCF];
    assign sr_mbb    = I_I2CSR[BIT_I2CSR_MBB];
    assign sr_mal    = I_I2CSR[BIT_I2CSR_MAL];
    assign sr_rxak   = I_I2CSR[BIT_I2CSR_RXAK];
    assign unused_sr = &{1'b0, I_I2CSR[BIT_I2CSR_MAAS], I_I2CSR[BIT_I2CSR_BCSTM],
                         I_I2CSR[BIT_I2CSR_SRW], I_I2CSR[BIT_I2CSR_MIF]};

    // MCF is only honoured on a rising edge and not within two cycles of a TXRX_DONE pulse
    assign mcf_evt = sr_mcf && !mcf_q && (hold_cnt == 2'd0);
    assign abort   = ((state != ST_IDLE) && (state != ST_FIN) && sr_mal) || to_hit;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .req       (I_REQ),
        .last_grant(last_grant),
        .gnt       (arb_gnt),
        .gnt_idx   (arb_idx),
        .gnt_valid (arb_valid)
    );

    // Mux the winning requester's address, direction and write byte
    always_comb begin
        sel_addr  = '0;
        sel_rw    = 1'b0;
        sel_wdata = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (arb_idx == IW'(i)) begin
                sel_addr  = I_DEV_ADDR[7*i +: 7];
                sel_rw    = I_RW[i];
                sel_wdata = I_WDATA[8*i +: 8];
            end
        end
    end

`ifdef I2C_ARB_TIMEOUT_EN
    logic [15:0] to_cnt;
    logic [3:0]  to_state;
    logic        in_wait;

    assign in_wait = (state == ST_ADDR_WAIT) || (state == ST_DATA_WAIT) || (state == ST_STOP);
    assign to_hit  = in_wait && (state == to_state) && (to_cnt == 16'(TIMEOUT_CYCLES));

    // Watchdog restarts whenever a wait state is (re)entered
    always_ff @(posedge I_CLK or negedge I_RSTN) begin
        if (!I_RSTN) begin
            to_cnt   <= '0;
            to_state <= ST_IDLE;
        end else begin
            to_state <= state;
            if (!in_wait || (state != to_state))
                to_cnt <= '0;
            else if (to_cnt != 16'(TIMEOUT_CYCLES))
                to_cnt <= to_cnt + 16'd1;
        end
    end
`else
    logic [15:0] unused_to;
    assign unused_to = 16'(TIMEOUT_CYCLES);
    assign to_hit    = 1'b0;
`endif

    // Transaction sequencer driving the master's register interface
    always_ff @(posedge I_CLK or negedge I_RSTN) begin
        if (!I_RSTN) begin
            state       <= ST_IDLE;
            last_grant  <= IW'(NUM_REQ - 1);
            cur_idx     <= '0;
            addr_q      <= '0;
            rw_q        <= 1'b0;
            wdata_q     <= '0;
            rd_byte     <= '0;
            err_q       <= 1'b0;
            rd_valid    <= 1'b0;
            mcf_q       <= 1'b0;
            hold_cnt    <= '0;
            O_GNT       <= '0;
            O_DONE      <= '0;
            O_ERR       <= 1'b0;
            O_RDATA     <= '0;
            O_I2CCR     <= '0;
            O_I2CDR     <= '0;
            O_I2CFDR    <= FDR_VAL;
            O_TXRX_DONE <= 1'b1;
        end else begin
            mcf_q       <= sr_mcf;
            O_DONE      <= '0;
            O_ERR       <= 1'b0;
            O_TXRX_DONE <= 1'b1;
            O_I2CFDR    <= FDR_VAL;
            if (hold_cnt != 2'd0)
                hold_cnt <= hold_cnt - 2'd1;

            if (abort) begin
                err_q   <= 1'b1;
                O_I2CCR <= '0;
                state   <= ST_FIN;
            end else begin
                case (state)
                    ST_IDLE: if (|I_REQ && !sr_mbb) state <= ST_ARB;
                    ST_ARB: begin
                        if (arb_valid) begin
                            O_GNT    <= arb_gnt;
                            cur_idx  <= arb_idx;
                            addr_q   <= sel_addr;
                            rw_q     <= sel_rw;
                            wdata_q  <= sel_wdata;
                            err_q    <= 1'b0;
                            rd_valid <= 1'b0;
                            state    <= ST_START;
                        end else begin
                            state    <= ST_IDLE;
                        end
                    end
                    ST_START: begin
                        O_I2CCR <= CR_RUN_TX;
                        O_I2CDR <= {addr_q, rw_q};
                        state   <= ST_ADDR_WAIT;
                    end
                    ST_ADDR_WAIT: if (mcf_evt) begin
                        O_TXRX_DONE <= 1'b0;
                        hold_cnt    <= 2'd2;
                        state       <= ST_ADDR_CHK;
                    end
                    ST_ADDR_CHK: begin
                        if (sr_rxak) begin
                            err_q   <= 1'b1;
                            O_I2CCR <= CR_EN;
                            state   <= ST_STOP;
                        end else begin
                            state   <= ST_DATA;
                        end
                    end
                    ST_DATA: begin
                        if (rw_q) O_I2CCR <= CR_RUN_RX;
                        else      O_I2CDR <= wdata_q;
                        state <= ST_DATA_WAIT;
                    end
                    ST_DATA_WAIT: if (mcf_evt) begin
                        O_TXRX_DONE <= 1'b0;
                        hold_cnt    <= 2'd2;
                        if (rw_q) begin
                            rd_byte  <= I_I2CDR;
                            rd_valid <= 1'b1;
                        end else if (sr_rxak) begin
                            err_q    <= 1'b1;
                        end
                        O_I2CCR <= CR_EN;
                        state   <= ST_STOP;
                    end
                    ST_STOP: begin
                        O_I2CCR <= CR_EN;
                        // Leave only once MSTA is already low so a stale MBB cannot end the STOP early
                        if (!O_I2CCR[BIT_I2CCR_MSTA] && !sr_mbb)
                            state <= ST_FIN;
                    end
                    ST_FIN: begin
                        O_DONE     <= O_GNT;
                        O_ERR      <= err_q;
                        if (rw_q && rd_valid)
                            O_RDATA <= rd_byte;
                        last_grant <= cur_idx;
                        O_GNT      <= '0;
                        state      <= ST_IDLE;
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_xfer_arbiter.sv
// Self-checking bench for i2c_xfer_arbiter: a behavioural i2c_master
// stand-in plus a round-robin/readback reference model.
module tb_i2c_xfer_arbiter;

    localparam int N   = 4;
    localparam int LIM = 60;
    localparam logic [7:0] CR_MEN  = 8'h80;
    localparam logic [7:0] CR_MSTA = 8'h20;
    localparam logic [7:0] CR_MTX  = 8'h10;
    localparam logic [7:0] CR_TXAK = 8'h08;

    logic           clk = 1'b0;
    logic           rstn;
    logic [N-1:0]   req;
    logic [7*N-1:0] dev_addr;
    logic [N-1:0]   rw;
    logic [8*N-1:0] wdata;
    logic [N-1:0]   gnt, done;
    logic           err, txrx_done;
    logic [7:0]     rdata, cr, dr, fdr, sr, mdr;
    logic           mcf, mbb, mal, rxak;

    assign sr = {mcf, 1'b0, mbb, mal, 3'b000, rxak};

    always #5 clk = ~clk;

    i2c_xfer_arbiter #(.NUM_REQ(N), .FDR_VAL(8'h2B), .TIMEOUT_CYCLES(30)) dut (
        .I_CLK(clk), .I_RSTN(rstn), .I_REQ(req), .I_DEV_ADDR(dev_addr), .I_RW(rw),
        .I_WDATA(wdata), .O_GNT(gnt), .O_DONE(done), .O_ERR(err), .O_RDATA(rdata),
        .O_I2CCR(cr), .O_I2CDR(dr), .O_I2CFDR(fdr), .O_TXRX_DONE(txrx_done),
        .I_I2CSR(sr), .I_I2CDR(mdr)
    );

    int n_checks = 0, n_pass = 0, n_fail = 0;

    // reference model state
    int         last_model = N - 1;
    logic [7:0] rdata_model = 8'h00;
    logic [6:0] a_addr[N];
    logic       a_rw[N];
    logic [7:0] a_wd[N];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int rr_pick(input logic [N-1:0] v, input int last);
        for (int k = 1; k <= N; k++) begin
            int c;
            c = (last + k) % N;
            if (v[c]) return c;
        end
        return -1;
    endfunction

    task automatic drive_reqs(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) begin
            dev_addr[7*i +: 7] = a_addr[i];
            rw[i]              = a_rw[i];
            wdata[8*i +: 8]    = a_wd[i];
        end
        req = v;
    endtask

    // mode: 0 normal, 1 arbitration loss in data phase, 2 reset in data phase
    task automatic serve(input int ei, input bit a_ack, input bit d_ack, input int mode,
                         input logic [7:0] rbyte, input bit drop_req, input bit hold);
        int t;
        bit rd, exp_err, seen;
        logic [7:0] abyte;
        rd      = a_rw[ei];
        abyte   = {a_addr[ei], a_rw[ei]};
        exp_err = !a_ack || (mode == 1) || (!rd && !d_ack);

        t = 0;
        while (!cr[5] && t < LIM) begin @(negedge clk); t++; end
        chk("start_cr", cr, CR_MEN | CR_MSTA | CR_MTX);
        chk("addr_dr", dr, abyte);
        chk("gnt", gnt, 1 << ei);
        if (drop_req) req = '0;
        mbb = 1'b1;
        repeat (3) @(negedge clk);
        chk("txrx_idle", txrx_done, 1);
        mcf = 1'b1; rxak = !a_ack;
        t = 0;
        while (txrx_done !== 1'b0 && t < LIM) begin @(negedge clk); t++; end
        chk("addr_txrx_lo", txrx_done, 0);
        mcf = 1'b0;
        @(negedge clk);
        chk("addr_txrx_hi", txrx_done, 1);

        if (a_ack) begin
            repeat (4) @(negedge clk);
            if (rd) chk("rd_cr", cr, CR_MEN | CR_MSTA | CR_TXAK);
            else begin
                chk("wr_cr", cr, CR_MEN | CR_MSTA | CR_MTX);
                chk("wr_dr", dr, a_wd[ei]);
            end
            if (mode == 2) begin
                rstn = 1'b0;
                #1;
                chk("rst_gnt", gnt, 0);
                chk("rst_cr", cr, 0);
                chk("rst_dr", dr, 0);
                chk("rst_txrx", txrx_done, 1);
                chk("rst_rdata", rdata, 0);
                chk("rst_fdr", fdr, 8'h2B);
                mcf = 1'b0; mbb = 1'b0; rxak = 1'b0; req = '0;
                @(negedge clk);
                chk("rst_done", done, 0);
                rstn = 1'b1;
                last_model  = N - 1;
                rdata_model = 8'h00;
                seen = 1'b0;
                repeat (8) begin @(negedge clk); if (done != 0) seen = 1'b1; end
                chk("no_done_after_rst", seen, 0);
                return;
            end else if (mode == 1) begin
                mal = 1'b1;
                @(negedge clk);
                chk("mal_cr", cr, 0);
            end else begin
                mdr = rbyte; rxak = rd ? 1'b1 : !d_ack; mcf = 1'b1;
                t = 0;
                while (txrx_done !== 1'b0 && t < LIM) begin @(negedge clk); t++; end
                chk("data_txrx_lo", txrx_done, 0);
                mcf = 1'b0;
                @(negedge clk);
                chk("data_txrx_hi", txrx_done, 1);
                chk("stop_cr", cr, CR_MEN);
                repeat (2) @(negedge clk);
                mbb = 1'b0;
            end
        end else begin
            chk("nack_cr", cr, CR_MEN);
            chk("nack_dr", dr, abyte);
            repeat (2) @(negedge clk);
            mbb = 1'b0;
        end

        t = 0;
        while (done == 0 && t < LIM) begin @(negedge clk); t++; end
        if (!hold) req = '0;
        mal = 1'b0; mbb = 1'b0; rxak = 1'b0;
        chk("done", done, 1 << ei);
        chk("err", err, exp_err);
        if (rd && a_ack && mode == 0) rdata_model = rbyte;
        chk("rdata", rdata, rdata_model);
        chk("gnt_drop", gnt, 0);
        last_model = ei;
        @(negedge clk);
        chk("done_pulse", done, 0);
    endtask

    initial begin
        int ei, t;
        logic [N-1:0] v;
        rstn = 1'b0; req = '0; dev_addr = '0; rw = '0; wdata = '0;
        mcf = 1'b0; mbb = 1'b0; mal = 1'b0; rxak = 1'b0; mdr = '0;
        for (int i = 0; i < N; i++) begin a_addr[i] = '0; a_rw[i] = 1'b0; a_wd[i] = '0; end
        repeat (3) @(negedge clk);
        chk("reset_gnt", gnt, 0);
        chk("reset_done", done, 0);
        chk("reset_err", err, 0);
        chk("reset_rdata", rdata, 0);
        chk("reset_cr", cr, 0);
        chk("reset_dr", dr, 0);
        chk("reset_fdr", fdr, 8'h2B);
        chk("reset_txrx", txrx_done, 1);
        rstn = 1'b1;
        @(negedge clk);

        // write 0x5A to 0x50 from requester 1, with request-to-grant latency
        a_addr[1] = 7'h50; a_rw[1] = 1'b0; a_wd[1] = 8'h5A;
        drive_reqs(4'b0010);
        @(negedge clk); chk("gnt_lat1", gnt, 0);
        @(negedge clk); chk("gnt_lat2", gnt, 4'b0010);
        serve(rr_pick(4'b0010, last_model), 1, 1, 0, 8'h00, 0, 0);

        // read from 0x48 by requester 2, slave returns 0xC3
        a_addr[2] = 7'h48; a_rw[2] = 1'b1;
        drive_reqs(4'b0100);
        serve(rr_pick(4'b0100, last_model), 1, 1, 0, 8'hC3, 0, 0);

        // write after read: read byte must hold; data NACK flags error
        a_addr[0] = 7'h11; a_rw[0] = 1'b0; a_wd[0] = 8'h3C;
        drive_reqs(4'b0001);
        serve(rr_pick(4'b0001, last_model), 1, 0, 0, 8'h00, 0, 0);

        // address NACK
        a_addr[3] = 7'h22; a_rw[3] = 1'b1;
        drive_reqs(4'b1000);
        serve(rr_pick(4'b1000, last_model), 0, 1, 0, 8'h77, 0, 0);

        // arbitration lost during data phase of a read
        a_addr[2] = 7'h33; a_rw[2] = 1'b1;
        drive_reqs(4'b0100);
        serve(rr_pick(4'b0100, last_model), 1, 1, 1, 8'hEE, 0, 0);

        // requester withdraws after grant; completion still reported
        a_addr[1] = 7'h0F; a_rw[1] = 1'b0; a_wd[1] = 8'h81;
        drive_reqs(4'b0010);
        serve(rr_pick(4'b0010, last_model), 1, 1, 0, 8'h00, 1, 0);

        // reset in data phase
        a_addr[0] = 7'h7E; a_rw[0] = 1'b1;
        drive_reqs(4'b0001);
        serve(rr_pick(4'b0001, last_model), 1, 1, 2, 8'h55, 0, 0);

        // all four requesting continuously after reset
        for (int i = 0; i < N; i++) begin
            a_addr[i] = 7'(8'h40 + i); a_rw[i] = 1'(i % 2); a_wd[i] = 8'(8'h10 * i + 1);
        end
        drive_reqs(4'b1111);
        for (int k = 0; k < N; k++) begin
            ei = rr_pick(4'b1111, last_model);
            serve(ei, 1, 1, 0, 8'(8'hA0 + k), 0, (k != N - 1));
        end

        // randomized traffic
        for (int it = 0; it < 20; it++) begin
            for (int i = 0; i < N; i++) begin
                a_addr[i] = 7'($urandom); a_rw[i] = 1'($urandom); a_wd[i] = 8'($urandom);
            end
            v = 4'($urandom_range(1, 15));
            drive_reqs(v);
            serve(rr_pick(v, last_model), ($urandom % 5) != 0, ($urandom % 5) != 0, 0,
                  8'($urandom), 0, 0);
        end

`ifdef I2C_ARB_TIMEOUT_EN
        // stuck bus: MCF never rises
        a_addr[2] = 7'h19; a_rw[2] = 1'b0; a_wd[2] = 8'h42;
        drive_reqs(4'b0100);
        ei = rr_pick(4'b0100, last_model);
        t = 0;
        while (!cr[5] && t < LIM) begin @(negedge clk); t++; end
        chk("to_start_cr", cr, CR_MEN | CR_MSTA | CR_MTX);
        mbb = 1'b1; req = '0;
        t = 0;
        while (done == 0 && t < 200) begin @(negedge clk); t++; end
        chk("to_done", done, 1 << ei);
        chk("to_err", err, 1);
        chk("to_cr", cr, 0);
        mbb = 1'b0;
        last_model = ei;
        @(negedge clk);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
